// File: rtl/tt_seq_pkg.sv
// Shared definitions for the truth-table sequencer.
//   tt_state_t    : sweep FSM states (IDLE, RUN, DONE)
//   Q6_EXPECTED   : default truth table, Y=1 only for inputs 010 and 101
//   expected_bit  : looks up the required Y for one input vector
package tt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_t;

  localparam logic [7:0] Q6_EXPECTED = 8'h24;

  // The table is always carried at its widest size (N_IN=8 -> 256 entries);
  // narrower configurations only ever address the low 2**N_IN bits.
  function automatic logic expected_bit(input logic [255:0] tbl,
                                        input logic [7:0]   idx);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable down-counter that times how long each vector is held.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (count -> 0)
//   load       : reload the count with SETTLE-1
//   en         : decrement by one (ignored while load is high or count is 0)
//   zero       : count is at zero, i.e. this is the last settle cycle
module settle_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-checking stimulus engine for a small 1-output combinational block.
// On start it applies every input vector in binary order, holds each for
// SETTLE cycles, samples y_in on the last settle cycle and compares it with
// the EXPECTED truth table, counting mismatches and capturing the first one.
// Ports:
//   clk, reset  : clock (rising edge), asynchronous active-high reset
//   start       : run one full sweep (only honoured in IDLE)
//   stim        : vector driven to the block under test, MSB is input A
//   y_in        : output of the block under test
//   busy        : sweep in progress
//   done        : one-cycle pulse at the end of a sweep
//   pass        : last sweep had no mismatches (held until next start/reset)
//   err_count   : mismatching vectors in the current/last sweep
//   fail_valid  : at least one mismatch seen in this sweep
//   fail_index  : index of the first mismatching vector
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int           N_IN     = 3,
  parameter logic [255:0] EXPECTED = 256'(Q6_EXPECTED),
  parameter int           SETTLE   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_index
);

  if ((N_IN < 1) || (N_IN > 8)) begin : g_bad_n_in
    $error("truth_table_sequencer: N_IN=%0d outside 1..8", N_IN);
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("truth_table_sequencer: SETTLE=%0d must be at least 1", SETTLE);
  end

  localparam logic [N_IN-1:0] IDX_ONE = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE = (N_IN + 1)'(1);

  tt_state_t         state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   fail_index_q, fail_index_d;

  logic              t_load;
  logic              t_en;
  logic              t_zero;
  logic              last_vec;
  logic              exp_y;
  logic              mismatch;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .en    (t_en),
    .zero  (t_zero)
  );

  assign last_vec = &idx_q;
  assign exp_y    = expected_bit(EXPECTED, 8'(idx_q));
  // Case inequality so an X or Z on y_in is scored as a failure in
  // simulation; synthesis reduces it to a plain inequality.
  assign mismatch = (y_in !== exp_y);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_index_d = fail_index_q;
    t_load       = 1'b0;
    t_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d        = '0;
          t_load       = 1'b1;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_index_d = '0;
          state_d      = RUN;
        end
      end

      RUN: begin
        if (!t_zero) begin
          t_en = 1'b1;
        end else begin
          if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_index_d = idx_q;
            end
          end
          if (last_vec) begin
            // Verdict must include the vector being scored this cycle,
            // hence err_d rather than err_q.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d  = idx_q + IDX_ONE;
            t_load = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_index_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_index_q <= fail_index_d;
    end
  end

  // The applied vector is always the current index, so one register serves
  // both; it keeps the last (all-ones) vector after a sweep.
  assign stim       = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
`timescale 1ns/1ps
module tb_truth_table_sequencer;

  localparam logic [7:0] TT_BITS = 8'h24;

  typedef struct packed {
    logic       pass;
    logic [3:0] err;
    logic       fv;
    logic [2:0] fi;
  } res_t;

  res_t sb_q[$];

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int mode4 = 0;
  int mode1 = 0;

  logic       start4 = 1'b0;
  logic [2:0] stim4;
  logic       y4;
  logic       busy4, done4, pass4, fv4;
  logic [3:0] err4;
  logic [2:0] fi4;

  logic       start1 = 1'b0;
  logic [2:0] stim1;
  logic       y1;
  logic       busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] fi1;

  // mode 0: correct block, 1: stuck at 0, 2: inverted, 3: X on vector 5
  function automatic logic model_y(input int mode, input logic [2:0] v);
    logic [7:0] tt;
    tt = TT_BITS;
    case (mode)
      0:       return tt[v];
      1:       return 1'b0;
      2:       return ~tt[v];
      3:       return (v == 3'd5) ? 1'bx : tt[v];
      default: return tt[v];
    endcase
  endfunction

  assign #0.005 y4 = model_y(mode4, stim4);
  assign #0.005 y1 = model_y(mode1, stim1);

  truth_table_sequencer #(
    .N_IN(3), .EXPECTED(256'h24), .SETTLE(4)
  ) dut4 (
    .clk(clk), .reset(reset), .start(start4), .stim(stim4), .y_in(y4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .fail_valid(fv4), .fail_index(fi4)
  );

  truth_table_sequencer #(
    .N_IN(3), .EXPECTED(256'h24), .SETTLE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stim(stim1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_index(fi1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int mode);
    res_t r;
    logic [7:0] tt;
    logic yv;
    tt = TT_BITS;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      yv = model_y(mode, 3'(i));
      if (yv !== tt[i]) begin
        if (!r.fv) begin
          r.fv = 1'b1;
          r.fi = 3'(i);
        end
        r.err = r.err + 4'd1;
      end
    end
    r.pass = (r.err == 4'd0);
    sb_q.push_back(r);
  endtask

  task automatic compare_result(input string name, input res_t got);
    res_t exp;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got pass=%0b err=%0d fv=%0b fi=%0d",
               name, got.pass, got.err, got.fv, got.fi);
    end else begin
      exp = sb_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got pass=%0b err=%0d fv=%0b fi=%0d, want pass=%0b err=%0d fv=%0b fi=%0d",
                 name, got.pass, got.err, got.fv, got.fi,
                 exp.pass, exp.err, exp.fv, exp.fi);
      end
    end
  endtask

  // One SETTLE=4 sweep; optional extra start pulses at k+10 and k+31.
  task automatic run_sweep4(input int mode, input bit extra, input string name);
    int   ndone;
    int   done_at;
    int   bad_stim_at;
    logic [2:0] exp_stim;
    res_t got;
    mode4 = mode;
    push_expected(mode);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1 || stim4 !== 3'd0 || err4 !== 4'd0 || fv4 !== 1'b0) begin
      errors++;
      $display("FAIL %s_launch: busy=%0b stim=%0d err=%0d fv=%0b, want 1 0 0 0",
               name, busy4, stim4, err4, fv4);
    end
    ndone = 0;
    done_at = -1;
    bad_stim_at = -1;
    got = {pass4, err4, fv4, fi4};
    for (int c = 1; c <= 40; c++) begin
      start4 = extra && (c == 10 || c == 31);
      tick();
      if (c <= 32) begin
        exp_stim = (c / 4 > 7) ? 3'd7 : 3'(c / 4);
        if (stim4 !== exp_stim && bad_stim_at < 0) bad_stim_at = c;
      end
      if (done4 === 1'b1) begin
        ndone++;
        done_at = c;
        got = {pass4, err4, fv4, fi4};
      end
    end
    start4 = 1'b0;
    checks++;
    if (bad_stim_at >= 0) begin
      errors++;
      $display("FAIL %s_stim: wrong stim first at cycle k+%0d, want floor(c/4)", name, bad_stim_at);
    end
    checks++;
    if (ndone != 1 || done_at != 32) begin
      errors++;
      $display("FAIL %s_done: %0d pulses, last at k+%0d, want 1 at k+32", name, ndone, done_at);
    end
    compare_result(name, got);
    checks++;
    if (busy4 !== 1'b0 || stim4 !== 3'd7) begin
      errors++;
      $display("FAIL %s_after: busy=%0b stim=%0d, want 0 7", name, busy4, stim4);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({stim4, busy4, done4, pass4, err4, fv4, fi4} !== '0 ||
        {stim1, busy1, done1, pass1, err1, fv1, fi1} !== '0) begin
      errors++;
      $display("FAIL reset_state: dut4 outs=%h dut1 outs=%h, want 0",
               {stim4, busy4, done4, pass4, err4, fv4, fi4},
               {stim1, busy1, done1, pass1, err1, fv1, fi1});
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy4=%0b done4=%0b busy1=%0b, want 0",
               busy4, done4, busy1);
    end
  endtask

  task automatic test_correct();
    run_sweep4(0, 1'b0, "correct");
  endtask

  task automatic test_stuck0();
    run_sweep4(1, 1'b0, "stuck0");
  endtask

  task automatic test_inverse();
    run_sweep4(2, 1'b0, "inverse");
  endtask

  task automatic test_extra_start();
    run_sweep4(0, 1'b1, "extra_start");
  endtask

  task automatic test_async_reset();
    int ndone;
    mode4 = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 13; c++) tick();
    checks++;
    if (stim4 !== 3'd3) begin
      errors++;
      $display("FAIL abort_setup: stim=%0d, want 3", stim4);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({stim4, busy4, done4, pass4, err4, fv4, fi4} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: outs=%h, want 0", {stim4, busy4, done4, pass4, err4, fv4, fi4});
    end
    #2 reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done4 === 1'b1 || busy4 === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d cycles with done/busy, want 0", ndone);
    end
    run_sweep4(0, 1'b0, "after_abort");
  endtask

  task automatic sweep1(input string name, output int done_at, output res_t got);
    done_at = -1;
    got = {pass1, err1, fv1, fi1};
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done1 === 1'b1) begin
        done_at = c;
        got = {pass1, err1, fv1, fi1};
        break;
      end
    end
    checks++;
    if (done_at != 8) begin
      errors++;
      $display("FAIL %s_done: done at k+%0d, want k+8", name, done_at);
    end
  endtask

  task automatic test_back_to_back();
    int   done_at;
    res_t got;
    mode1 = 0;
    push_expected(0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    sweep1("s1_first", done_at, got);
    compare_result("s1_first", got);
    tick();
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL s1_gap: done=%0b busy=%0b, want 0 0", done1, busy1);
    end
    mode1 = 3;
    push_expected(3);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (err1 !== 4'd0 || busy1 !== 1'b1 || fv1 !== 1'b0 || pass1 !== 1'b0) begin
      errors++;
      $display("FAIL s1_restart: err=%0d busy=%0b fv=%0b pass=%0b, want 0 1 0 0",
               err1, busy1, fv1, pass1);
    end
    sweep1("s1_xval", done_at, got);
    compare_result("s1_xval", got);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_correct();
    test_stuck0();
    test_inverse();
    test_extra_start();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Drive end of the small combinational-DUT interface used by the gate-level exercises. It applies every input combination to a 1-output combinational block, in binary order, and holds each combination for a programmable settle time.
- On the last settle cycle of each vector it samples the DUT output and compares it against an expected truth table held as a parameter vector.
- It counts mismatches and records the first failing index. Used as a reusable self-checking stimulus engine in gate-delay testbenches, or as an on-chip BIST for a tiny logic block.

Parameters:
- N_IN, 3, number of DUT inputs; legal range 1..8.
- EXPECTED, 8'h24, expected truth table; bit i is the required Y for input vector i. Only the low 2**N_IN bits are used. 8'h24 means Y=1 only for 010 and 101.
- SETTLE, 4, clock cycles each vector is held; legal minimum 1. Y is sampled on the last cycle.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to run one full sweep; sampled only in IDLE.
- stim  output  N_IN  vector driven to the DUT. MSB is input A; for N_IN=3, stim = {A,B,C}.
- y_in  input  1  DUT output, treated as asynchronous to the sweep; no synchroniser.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high after a sweep with zero mismatches; held until the next start or reset.
- err_count  output  N_IN+1  number of mismatching vectors in the last or current sweep.
- fail_valid  output  1  high once at least one mismatch has occurred in this sweep.
- fail_index  output  N_IN  index of the first mismatching vector; valid when fail_valid is high.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_index=0, internal index=0, settle counter=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - stim<=0, idx<=0, cnt<=SETTLE-1, busy<=1.
  - pass<=0, err_count<=0, fail_valid<=0, fail_index<=0.
  - Next state RUN.
- RUN, each edge:
  - If cnt!=0: cnt<=cnt-1; stim unchanged.
  - If cnt==0: compare y_in with EXPECTED[idx].
    - On mismatch: err_count<=err_count+1.
    - On the first mismatch also set fail_valid<=1 and fail_index<=idx.
    - If idx==2**N_IN-1: next state DONE. Otherwise idx<=idx+1, stim<=idx+1, cnt<=SETTLE-1.
- Sample timing: vector i is sampled at edge k+(i+1)*SETTLE. With SETTLE=1, the sample is taken at the edge after the vector is applied.
- DONE:
  - Entered at edge k+2**N_IN*SETTLE.
  - In that same edge: busy<=0, done<=1; pass<=1 iff the final err_count (including the last vector) is 0.
  - Next edge: done<=0, state IDLE.
- After the sweep, stim holds the last vector (all ones) until the next start.
- A start that is high during RUN or DONE is ignored. It is not queued.
- A start in the IDLE cycle immediately after done restarts cleanly; back-to-back sweeps are legal.
- y_in equal to X or Z at a sample counts as a mismatch. Use case-inequality in simulation; synthesis treats it as != .
- err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- Reset asserted mid-run aborts the sweep immediately. No done pulse is produced, and all outputs go to their reset values.
- Parameter legality (N_IN 1..8, SETTLE>=1) is checked at elaboration with $error.

Decomposition:
- Package tt_seq_pkg holds:
  - state enum tt_state_t {IDLE, RUN, DONE};
  - constant Q6_EXPECTED = 8'h24;
  - helper function expected_bit(table, idx).
- One natural sub-module, settle_timer: a loadable down-counter sized to $clog2(SETTLE)+1, with load and zero outputs.
- The top level holds the FSM, the index counter and the checker.

Test Plan:
- 1. Correct DUT model (5ps gate delays), SETTLE=4, pulse start at edge k.
  - stim steps 0..7, each held 4 cycles.
  - done pulses at edge k+32; pass=1, err_count=0, fail_valid=0.
- 2. Y stuck at 0.
  - err_count=2, fail_valid=1, fail_index=2, pass=0.
- 3. Y is the inverse of the correct function.
  - err_count=8, fail_index=0, pass=0.
- 4. Correct DUT; extra start pulses at k+10 and k+31.
  - Exactly one done, at k+32; no restart; results as in test 1.
- 5. reset asserted asynchronously while stim=3, mid-settle.
  - All outputs go to 0 before the next edge; no done pulse.
  - A new start then gives the full clean sweep of test 1.
- 6. SETTLE=1; start asserted in the cycle immediately after done.
  - Second sweep begins with err_count cleared to 0; done pulses 8 cycles later.
  - y_in driven X on vector 5 gives err_count=1, fail_index=5.
